// File: rtl/sys_bridge_pkg.sv
// Shared types and default address map for the CPU-to-peripheral bridge.
package sys_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int WAIT_W = 8;

  localparam logic [31:0] DM_BASE     = 32'h0000_0000;
  localparam logic [31:0] DM_MASK     = 32'hffff_c000;
  localparam logic [31:0] TIMER0_BASE = 32'h0000_7f00;
  localparam logic [31:0] TIMER0_MASK = 32'hffff_fff0;
  localparam logic [31:0] TIMER1_BASE = 32'h0000_7f10;
  localparam logic [31:0] TIMER1_MASK = 32'hffff_fff0;
  localparam logic [31:0] INTGEN_BASE = 32'h0000_7f20;
  localparam logic [31:0] INTGEN_MASK = 32'hffff_fffc;

endpackage

// File: rtl/sys_bridge_v2_irq_sync_cell.sv
// One interrupt line: 2-flop synchroniser, then either level pass-through
// or rising-edge pending latch cleared by clr (set wins over clear).
module irq_sync_cell
  import sys_bridge_pkg::*;
#(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic clr,
  output logic hw
);

  logic sync_p0, sync_p1, sync_p2, pend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
      pend    <= 1'b0;
    end else begin
      sync_p0 <= irq;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
      pend    <= (sync_p1 & ~sync_p2) | (pend & ~clr);
    end
  end

  assign hw = EDGE ? pend : sync_p1;

endmodule

// File: rtl/sys_bridge_v2.sv
// Registered request/response bridge from the CPU data port to NSLOT slaves,
// with wait/timeout handling and interrupt collection. Optional error log: SYS_BRIDGE_ERRLOG_EN.
module sys_bridge_v2
  import sys_bridge_pkg::*;
#(
  parameter int                   NSLOT     = 4,
  parameter int                   DATA_W    = 32,
  parameter logic [NSLOT*32-1:0]  SLOT_BASE = {INTGEN_BASE, TIMER1_BASE, TIMER0_BASE, DM_BASE},
  parameter logic [NSLOT*32-1:0]  SLOT_MASK = {INTGEN_MASK, TIMER1_MASK, TIMER0_MASK, DM_MASK},
  parameter int                   TIMEOUT   = 15,
  parameter int                   NIRQ      = 6,
  parameter logic [NIRQ-1:0]      IRQ_EDGE  = 6'b000011
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [31:0]               cpu_addr,
  input  logic [DATA_W/8-1:0]       cpu_byteen,
  input  logic [DATA_W-1:0]         cpu_wdata,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_ready,
  output logic                      cpu_err,
  output logic [NSLOT-1:0]          slot_sel,
  output logic                      slot_we,
  output logic [31:0]               slot_addr,
  output logic [DATA_W/8-1:0]       slot_byteen,
  output logic [DATA_W-1:0]         slot_wdata,
  input  logic [NSLOT*DATA_W-1:0]   slot_rdata,
  input  logic [NSLOT-1:0]          slot_ready,
  input  logic [NIRQ-1:0]           irq_in,
  input  logic [NIRQ-1:0]           irq_clr,
  output logic [NIRQ-1:0]           hw_int
`ifdef SYS_BRIDGE_ERRLOG_EN
  ,
  input  logic                      err_log_clr,
  output logic                      err_valid,
  output logic [31:0]               err_addr
`endif
);

  state_t              state;
  logic [WAIT_W-1:0]   wcnt, wcnt_nxt;
  logic [NSLOT-1:0]    hit_oh;
  logic [DATA_W-1:0]   rd_mux;
  logic                we_eff, rdy_hit, tmo_hit;

  // Descending scan so the lowest matching slot is the last assignment.
  always_comb begin
    hit_oh = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if ((cpu_addr & SLOT_MASK[32*i +: 32]) == SLOT_BASE[32*i +: 32]) begin
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (slot_sel[i]) rd_mux |= slot_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign we_eff   = cpu_we & (|cpu_byteen);
  assign rdy_hit  = |(slot_ready & slot_sel);
  assign wcnt_nxt = wcnt + 1'b1;
  assign tmo_hit  = (wcnt_nxt == WAIT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wcnt        <= '0;
      cpu_rdata   <= '0;
      cpu_ready   <= 1'b0;
      cpu_err     <= 1'b0;
      slot_sel    <= '0;
      slot_we     <= 1'b0;
      slot_addr   <= '0;
      slot_byteen <= '0;
      slot_wdata  <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            slot_addr  <= cpu_addr;
            slot_wdata <= cpu_wdata;
            wcnt       <= '0;
            if (|hit_oh) begin
              state       <= ACCESS;
              slot_sel    <= hit_oh;
              slot_we     <= we_eff;
              slot_byteen <= we_eff ? cpu_byteen : '0;
            end else begin
              state     <= RESP;
              cpu_ready <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (rdy_hit || tmo_hit) begin
            state       <= RESP;
            cpu_ready   <= 1'b1;
            cpu_err     <= ~rdy_hit;
            cpu_rdata   <= (rdy_hit && !slot_we) ? rd_mux : '0;
            slot_sel    <= '0;
            slot_we     <= 1'b0;
            slot_byteen <= '0;
          end else begin
            wcnt <= wcnt_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SYS_BRIDGE_ERRLOG_EN
  logic        err_evt;
  logic [31:0] err_evt_addr;

  assign err_evt = ((state == IDLE) && cpu_req && !(|hit_oh)) ||
                   ((state == ACCESS) && !rdy_hit && tmo_hit);
  assign err_evt_addr = (state == IDLE) ? cpu_addr : slot_addr;

  // A clear in the same cycle as a new error still records the new one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else if (err_evt && (!err_valid || err_log_clr)) begin
      err_valid <= 1'b1;
      err_addr  <= err_evt_addr;
    end else if (err_log_clr) begin
      err_valid <= 1'b0;
    end
  end
`endif

  for (genvar g = 0; g < NIRQ; g++) begin : g_irq
    irq_sync_cell #(.EDGE(IRQ_EDGE[g])) u_cell (
      .clk   (clk),
      .reset (reset),
      .irq   (irq_in[g]),
      .clr   (irq_clr[g]),
      .hw    (hw_int[g])
    );
  end

endmodule
